// File: rtl/fp_expand.sv
// Iterative expander from the 8-bit {S,E[2:0],F[3:0]} float to a 12-bit two's-complement value.
// Define FP_EXPAND_ROUND_EN to rebuild the midpoint of the truncated range instead of the floor.
module fp_expand (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_fp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_data,
  output logic        busy
);

`ifdef FP_EXPAND_ROUND_EN
  localparam bit P_ROUND_EN = 1'b1;
`else
  localparam bit P_ROUND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_SIGN,
    ST_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic        [11:0] r_mag, w_mag_nxt;
  logic        [2:0]  r_cnt, w_cnt_nxt;
  logic        [2:0]  r_e, w_e_nxt;
  logic               r_s, w_s_nxt;
  logic               r_in_ready, w_in_ready_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic        [11:0] r_out_data, w_out_data_nxt;
  logic               r_busy, w_busy_nxt;

  // Midpoint of the bits the encoder dropped below the significand; zero and E=0 have none.
  function automatic logic [11:0] f_round(input logic [11:0] mag, input logic [2:0] e);
    logic [11:0] half;
    half = (e == 3'd0) ? 12'd0 : (12'd1 << (e - 3'd1));
    if (P_ROUND_EN && (mag != 12'd0))
      return mag | half;
    return mag;
  endfunction

  // Magnitude never reaches 2048, so negation cannot overflow; -0 folds to 0 naturally.
  function automatic logic signed [11:0] f_apply_sign(input logic [11:0] m, input logic s);
    logic signed [11:0] sm;
    sm = $signed(m);
    return s ? -sm : sm;
  endfunction

  always_comb begin
    w_state_nxt     = r_state;
    w_mag_nxt       = r_mag;
    w_cnt_nxt       = r_cnt;
    w_e_nxt         = r_e;
    w_s_nxt         = r_s;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_mag_nxt   = {8'd0, in_fp[3:0]};
          w_cnt_nxt   = in_fp[6:4];
          w_e_nxt     = in_fp[6:4];
          w_s_nxt     = in_fp[7];
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt != 3'd0) begin
          w_mag_nxt = r_mag << 1;
          w_cnt_nxt = r_cnt - 3'd1;
        end else begin
          w_state_nxt = ST_SIGN;
        end
      end
      ST_SIGN: begin
        w_out_data_nxt  = f_apply_sign(f_round(r_mag, r_e), r_s);
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Status outputs are registered from the next state so they line up with r_state.
    w_in_ready_nxt = (w_state_nxt == ST_IDLE);
    w_busy_nxt     = (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_SIGN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mag       <= 12'd0;
      r_cnt       <= 3'd0;
      r_e         <= 3'd0;
      r_s         <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= 12'd0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mag       <= w_mag_nxt;
      r_cnt       <= w_cnt_nxt;
      r_e         <= w_e_nxt;
      r_s         <= w_s_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fp_expand.sv
// Bench for fp_expand: arithmetic reference model with a scoreboard plus directed literal vectors.
// Build with FP_EXPAND_ROUND_EN defined to exercise the midpoint-reconstruction variant.
module tb_fp_expand;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_fp;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];

`ifdef FP_EXPAND_ROUND_EN
  localparam logic [11:0] X_FF = 12'h7C0, X_BA = 12'hFAC, X_23 = 12'h00E;
  localparam logic [11:0] X_15 = 12'h00B, X_9F = 12'hFE1, X_11 = 12'h003;
`else
  localparam logic [11:0] X_FF = 12'h780, X_BA = 12'hFB0, X_23 = 12'h00C;
  localparam logic [11:0] X_15 = 12'h00A, X_9F = 12'hFE2, X_11 = 12'h002;
`endif

  fp_expand dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fp     (in_fp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Value = (-1)^S * F * 2^E, plus half an LSB of the dropped range when rounding is built in.
  function automatic logic [11:0] model(input logic [7:0] fp);
    int f, e, v;
    f = int'(fp[3:0]);
    e = int'(fp[6:4]);
    v = f * (2 ** e);
`ifdef FP_EXPAND_ROUND_EN
    if (e >= 1 && f != 0) v = v + 2 ** (e - 1);
`endif
    if (fp[7]) v = -v;
    return v[11:0];
  endfunction

  // Scoreboard: inputs change only just after posedge, so at negedge they show what the next edge does.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        chk("sb_result_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("sb_out_data", 32'(out_data), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_fp));
    end
  end

  always @(negedge rst_n) exp_q.delete();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string name, input logic [7:0] fp, input logic [11:0] req, input int req_lat);
    int lat;
    bit acc;
    bit got;
    acc = 1'b0;
    got = 1'b0;
    in_fp    = fp;
    in_valid = 1'b1;
    for (int i = 0; i < 30 && !acc; i++) begin
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    chk({name, "_accepted"}, 32'(acc), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    chk({name, "_in_ready_low"}, 32'(in_ready), 32'd0);
    lat = 0;
    for (int i = 0; i < 15 && !got; i++) begin
      tick();
      lat++;
      got = out_valid;
    end
    chk({name, "_latency"}, 32'(lat), 32'(req_lat));
    chk({name, "_data"}, 32'(out_data), 32'(req));
    if (out_ready) begin
      tick();
      chk({name, "_valid_drop"}, 32'(out_valid), 32'd0);
      chk({name, "_ready_back"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    int nres;
    int nacc;
    bit got;
    logic [11:0] seq_req [2];
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_fp     = 8'h00;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    run("max_pos", 8'b0_111_1111, X_FF, 9);
    run("neg_e3", 8'b1_011_1010, X_BA, 5);
    run("e0", 8'b0_000_0101, 12'h005, 2);
    run("neg_zero", 8'b1_101_0000, 12'h000, 7);

    // Backpressure: result must hold while stray in_valid pulses are ignored.
    out_ready = 1'b0;
    run("bp", 8'b0_010_0011, X_23, 4);
    for (int i = 0; i < 6; i++) begin
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data), 32'(X_23));
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      in_valid = i[0];
      in_fp    = 8'h7F;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_data_kept", 32'(out_data), 32'(X_23));

    // Back-to-back with in_valid held high.
    seq_req[0] = X_15;
    seq_req[1] = X_9F;
    nres = 0;
    nacc = 0;
    in_fp    = 8'h15;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && nres < 2; i++) begin
      got = in_valid && in_ready;
      tick();
      if (got) begin
        nacc++;
        if (nacc == 1) in_fp = 8'h9F;
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        chk("b2b_data", 32'(out_data), 32'(seq_req[nres]));
        nres++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_results", 32'(nres), 32'd2);
    chk("b2b_accepts", 32'(nacc), 32'd2);
    tick();

    // Asynchronous reset in the middle of a shift.
    in_fp    = 8'b0_111_0001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run("after_rst", 8'b0_001_0001, X_11, 3);
    for (int i = 0; i < 12; i++) begin
      chk("no_stale_valid", 32'(out_valid), 32'd0);
      tick();
    end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
